// File: rtl/fx_syn_ctrl.sv
// fx-bus register slave driving a microsecond-timed sync-pulse generator on tx_syn.
// Define FX_SYN_RXCNT_EN to build the rx_syn synchronizer and rising-edge counter (RXCNT).
module fx_syn_ctrl #(
    parameter logic [7:0] MOD_ID = 8'h01
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        pluse_us,
    input  logic [15:0] fx_waddr,
    input  logic        fx_wr,
    input  logic [7:0]  fx_data,
    input  logic [15:0] fx_raddr,
    input  logic        fx_rd,
    output logic [7:0]  fx_q,
    input  logic        rx_syn,
    output logic        tx_syn
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [7:0] OFS_CTRL   = 8'h00;
    localparam logic [7:0] OFS_PER_L  = 8'h01;
    localparam logic [7:0] OFS_PER_H  = 8'h02;
    localparam logic [7:0] OFS_WIDTH  = 8'h03;
    localparam logic [7:0] OFS_STATUS = 8'h04;
    localparam logic [7:0] OFS_CNT    = 8'h05;
    localparam logic [7:0] OFS_ID     = 8'h06;
    localparam logic [7:0] OFS_RXCNT  = 8'h07;

    state_t      state_reg, state_next;
    logic [15:0] us_cnt_reg, us_cnt_next;
    logic [15:0] low_len_reg, low_len_next;
    logic        en_reg, en_next;
    logic        oneshot_reg;
    logic [7:0]  shadow_reg;
    logic [15:0] period_reg;
    logic [7:0]  width_reg;
    logic [7:0]  cnt_reg;
    logic [7:0]  fx_q_reg;
    logic        tx_syn_reg;
    logic        cnt_inc;
    logic [7:0]  rd_data;
    logic [7:0]  rxcnt_val;
    logic        rx_sync;

    logic        wr_hit, rd_hit, wr_ctrl, clr;
    logic [15:0] p_eff, w_raw, w_eff;

    assign wr_hit  = fx_wr && (fx_waddr[15:8] == MOD_ID);
    assign rd_hit  = fx_rd && (fx_raddr[15:8] == MOD_ID);
    assign wr_ctrl = wr_hit && (fx_waddr[7:0] == OFS_CTRL);
    assign clr     = wr_ctrl && fx_data[2];

    // Effective timing: PERIOD >= 2, 1 <= WIDTH <= PERIOD-1, so the low phase is never empty.
    assign p_eff = (period_reg < 16'd2) ? 16'd2 : period_reg;
    assign w_raw = (width_reg == 8'd0) ? 16'd1 : {8'd0, width_reg};
    assign w_eff = (w_raw >= p_eff) ? (p_eff - 16'd1) : w_raw;

    always_comb begin
        state_next   = state_reg;
        us_cnt_next  = us_cnt_reg;
        low_len_next = low_len_reg;
        en_next      = en_reg;
        cnt_inc      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (en_reg && pluse_us) begin
                    state_next   = HIGH;
                    us_cnt_next  = w_eff;
                    low_len_next = p_eff - w_eff;
                end
            end
            HIGH: begin
                if (pluse_us) begin
                    if (us_cnt_reg <= 16'd1) begin
                        state_next  = LOW;
                        us_cnt_next = low_len_reg;
                        cnt_inc     = 1'b1;
                    end else begin
                        us_cnt_next = us_cnt_reg - 16'd1;
                    end
                end
            end
            LOW: begin
                if (pluse_us) begin
                    if (us_cnt_reg <= 16'd1) begin
                        if (oneshot_reg) begin
                            state_next = IDLE;
                            en_next    = 1'b0;
                        end else begin
                            state_next   = HIGH;
                            us_cnt_next  = w_eff;
                            low_len_next = p_eff - w_eff;
                        end
                    end else begin
                        us_cnt_next = us_cnt_reg - 16'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // A bus write to CTRL overrides the hardware EN clear; EN=0 abandons the cycle at once.
        if (wr_ctrl) begin
            en_next = fx_data[0];
            if (!fx_data[0]) begin
                state_next = IDLE;
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (fx_raddr[7:0])
            OFS_CTRL:   rd_data = {6'd0, oneshot_reg, en_reg};
            OFS_PER_L:  rd_data = shadow_reg;
            OFS_PER_H:  rd_data = period_reg[15:8];
            OFS_WIDTH:  rd_data = width_reg;
            OFS_STATUS: rd_data = {5'd0, rx_sync, tx_syn_reg, state_reg != IDLE};
            OFS_CNT:    rd_data = cnt_reg;
            OFS_ID:     rd_data = MOD_ID;
            OFS_RXCNT:  rd_data = rxcnt_val;
            default:    rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            us_cnt_reg  <= 16'd0;
            low_len_reg <= 16'd0;
            en_reg      <= 1'b0;
            oneshot_reg <= 1'b0;
            shadow_reg  <= 8'h00;
            period_reg  <= 16'h0000;
            width_reg   <= 8'h01;
            cnt_reg     <= 8'h00;
            fx_q_reg    <= 8'h00;
            tx_syn_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            us_cnt_reg  <= us_cnt_next;
            low_len_reg <= low_len_next;
            en_reg      <= en_next;
            tx_syn_reg  <= (state_next == HIGH);
            fx_q_reg    <= rd_hit ? rd_data : 8'h00;
            if (clr) begin
                cnt_reg <= 8'h00;
            end else if (cnt_inc) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
            if (wr_hit) begin
                case (fx_waddr[7:0])
                    OFS_CTRL:  oneshot_reg <= fx_data[1];
                    OFS_PER_L: shadow_reg  <= fx_data;
                    OFS_PER_H: period_reg  <= {fx_data, shadow_reg};
                    OFS_WIDTH: width_reg   <= fx_data;
                    default: ;
                endcase
            end
        end
    end

`ifdef FX_SYN_RXCNT_EN
    logic       rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [7:0] rxcnt_reg;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b0;
            rx_sync_reg <= 1'b0;
            rx_prev_reg <= 1'b0;
            rxcnt_reg   <= 8'h00;
        end else begin
            rx_meta_reg <= rx_syn;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            if (clr) begin
                rxcnt_reg <= 8'h00;
            end else if (rx_sync_reg && !rx_prev_reg) begin
                rxcnt_reg <= rxcnt_reg + 8'd1;
            end
        end
    end

    assign rx_sync   = rx_sync_reg;
    assign rxcnt_val = rxcnt_reg;
`else
    logic unused_rx_syn;

    assign unused_rx_syn = rx_syn;
    assign rx_sync       = 1'b0;
    assign rxcnt_val     = 8'h00;
`endif

    assign fx_q   = fx_q_reg;
    assign tx_syn = tx_syn_reg;
endmodule

// File: tb/tb_fx_syn_ctrl.sv
// Directed bench for fx_syn_ctrl: table-driven register vectors plus hand-written timing sequences.
module tb_fx_syn_ctrl;
    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic        pluse_us = 1'b0;
    logic [15:0] fx_waddr = 16'h0000;
    logic        fx_wr = 1'b0;
    logic [7:0]  fx_data = 8'h00;
    logic [15:0] fx_raddr = 16'h0000;
    logic        fx_rd = 1'b0;
    logic [7:0]  fx_q;
    logic        rx_syn = 1'b0;
    logic        tx_syn;

    int checks = 0;
    int failures = 0;

`ifdef FX_SYN_RXCNT_EN
    localparam bit RXEN = 1'b1;
`else
    localparam bit RXEN = 1'b0;
`endif

    fx_syn_ctrl #(.MOD_ID(8'h01)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .pluse_us(pluse_us),
        .fx_waddr(fx_waddr),
        .fx_wr   (fx_wr),
        .fx_data (fx_data),
        .fx_raddr(fx_raddr),
        .fx_rd   (fx_rd),
        .fx_q    (fx_q),
        .rx_syn  (rx_syn),
        .tx_syn  (tx_syn)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        is_wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp_q;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%02h required=%02h", name, act, exp_v);
        end
    endtask

    // One clock cycle with the given bus/tick inputs; outputs are stable on return.
    task automatic cyc(input logic wr, input logic [15:0] wa, input logic [7:0] wd,
                       input logic rd, input logic [15:0] ra, input logic tk);
        fx_wr = wr; fx_waddr = wa; fx_data = wd;
        fx_rd = rd; fx_raddr = ra; pluse_us = tk;
        @(posedge clk_sys);
        #1;
        fx_wr = 1'b0; fx_rd = 1'b0; pluse_us = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        cyc(1'b1, a, d, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic bus_rd(input logic [15:0] a, input string name, input logic [7:0] exp_v);
        cyc(1'b0, 16'h0, 8'h0, 1'b1, a, 1'b0);
        check8(name, fx_q, exp_v);
        idle(1);
        check8({name, "_idle"}, fx_q, 8'h00);
    endtask

    task automatic tick_chk(input string name, input logic exp_tx);
        cyc(1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b1);
        check8(name, {7'd0, tx_syn}, {7'd0, exp_tx});
        idle(1);
    endtask

    task automatic add(input logic w, input logic [15:0] a, input logic [7:0] d,
                       input logic [7:0] e, input string n);
        vec_t v;
        v.is_wr = w; v.addr = a; v.data = d; v.exp_q = e; v.name = n;
        vecs.push_back(v);
    endtask

    logic [11:0] exp5;

    initial begin
        // Register-access vectors from reset.
        add(1'b0, 16'h0106, 8'h00, 8'h01, "rd_id");
        add(1'b0, 16'h0103, 8'h00, 8'h01, "rd_width_rst");
        add(1'b0, 16'h0100, 8'h00, 8'h00, "rd_ctrl_rst");
        add(1'b0, 16'h0102, 8'h00, 8'h00, "rd_perh_rst");
        add(1'b0, 16'h0104, 8'h00, 8'h00, "rd_status_rst");
        add(1'b0, 16'h0105, 8'h00, 8'h00, "rd_cnt_rst");
        add(1'b0, 16'h0107, 8'h00, 8'h00, "rd_rxcnt_rst");
        add(1'b0, 16'h0108, 8'h00, 8'h00, "rd_unmapped");
        add(1'b0, 16'h0206, 8'h00, 8'h00, "rd_other_mod");
        add(1'b1, 16'h0203, 8'h55, 8'h00, "wr_other_mod");
        add(1'b0, 16'h0103, 8'h00, 8'h01, "rd_width_other_wr");
        add(1'b1, 16'h0103, 8'h07, 8'h00, "wr_width");
        add(1'b0, 16'h0103, 8'h00, 8'h07, "rd_width");
        add(1'b1, 16'h0101, 8'h34, 8'h00, "wr_perl");
        add(1'b0, 16'h0102, 8'h00, 8'h00, "rd_perh_before_commit");
        add(1'b1, 16'h0102, 8'h12, 8'h00, "wr_perh");
        add(1'b0, 16'h0102, 8'h00, 8'h12, "rd_perh");
        add(1'b1, 16'h0100, 8'h06, 8'h00, "wr_ctrl_os_clr");
        add(1'b0, 16'h0100, 8'h00, 8'h02, "rd_ctrl_clr_reads0");
        add(1'b1, 16'h0100, 8'h00, 8'h00, "wr_ctrl_zero");
        add(1'b0, 16'h0100, 8'h00, 8'h00, "rd_ctrl_zero");
        add(1'b1, 16'h01FF, 8'hAA, 8'h00, "wr_unmapped");
        add(1'b0, 16'h01FF, 8'h00, 8'h00, "rd_unmapped2");
        add(1'b1, 16'h0106, 8'h99, 8'h00, "wr_id_ro");
        add(1'b0, 16'h0106, 8'h00, 8'h01, "rd_id_ro");

        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        check8("rst_tx", {7'd0, tx_syn}, 8'h00);
        check8("rst_q", fx_q, 8'h00);

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) bus_wr(vecs[i].addr, vecs[i].data);
            else bus_rd(vecs[i].addr, vecs[i].name, vecs[i].exp_q);
        end

        // Periodic: PERIOD 10, WIDTH 3.
        bus_wr(16'h0101, 8'h0A);
        bus_wr(16'h0102, 8'h00);
        bus_wr(16'h0103, 8'h03);
        bus_wr(16'h0100, 8'h01);
        for (int k = 1; k <= 40; k++) tick_chk($sformatf("per10_k%0d", k), ((k - 1) % 10) < 3);
        bus_rd(16'h0105, "per10_cnt", 8'h04);
        bus_rd(16'h0104, "per10_status", 8'h01);
        bus_wr(16'h0100, 8'h00);
        bus_rd(16'h0104, "per10_stopped", 8'h00);

        // Oneshot: PERIOD 5, WIDTH 2.
        bus_wr(16'h0100, 8'h04);
        bus_rd(16'h0105, "clr_cnt", 8'h00);
        bus_wr(16'h0101, 8'h05);
        bus_wr(16'h0102, 8'h00);
        bus_wr(16'h0103, 8'h02);
        bus_wr(16'h0100, 8'h03);
        tick_chk("os_k1", 1'b1);
        bus_rd(16'h0104, "os_status_run", 8'h03);
        for (int k = 2; k <= 10; k++) tick_chk($sformatf("os_k%0d", k), k <= 2);
        bus_rd(16'h0100, "os_ctrl", 8'h02);
        bus_rd(16'h0104, "os_status_end", 8'h00);
        bus_rd(16'h0105, "os_cnt", 8'h01);

        // WIDTH >= PERIOD clamps to PERIOD-1; EN=0 mid-HIGH.
        bus_wr(16'h0101, 8'h10);
        bus_wr(16'h0102, 8'h00);
        bus_wr(16'h0103, 8'h20);
        bus_wr(16'h0100, 8'h01);
        for (int k = 1; k <= 20; k++) tick_chk($sformatf("clamp_k%0d", k), ((k - 1) % 16) < 15);
        bus_wr(16'h0100, 8'h00);
        check8("en_off_tx", {7'd0, tx_syn}, 8'h00);
        bus_rd(16'h0104, "en_off_status", 8'h00);
        bus_rd(16'h0105, "en_off_cnt", 8'h02);

        // PERIOD 1 -> 2, WIDTH 0 -> 1; new timing mid-HIGH applies only at next HIGH entry.
        exp5 = 12'b1100_1101_0101;
        bus_wr(16'h0101, 8'h01);
        bus_wr(16'h0102, 8'h00);
        bus_wr(16'h0103, 8'h00);
        bus_wr(16'h0100, 8'h01);
        for (int k = 1; k <= 12; k++) begin
            tick_chk($sformatf("bnd_k%0d", k), exp5[k - 1]);
            if (k == 5) begin
                bus_wr(16'h0103, 8'h02);
                bus_wr(16'h0101, 8'h04);
                bus_wr(16'h0102, 8'h00);
            end
        end
        // CLR coinciding with the HIGH->LOW tick that would increment CNT.
        cyc(1'b1, 16'h0100, 8'h05, 1'b0, 16'h0, 1'b1);
        check8("clr_inc_tx", {7'd0, tx_syn}, 8'h00);
        idle(1);
        bus_rd(16'h0105, "clr_wins_cnt", 8'h00);
        tick_chk("bnd_k14", 1'b0);
        tick_chk("bnd_k15", 1'b1);
        bus_wr(16'h0100, 8'h00);

        // Read and write of the same register in one cycle returns the old value.
        cyc(1'b1, 16'h0103, 8'h09, 1'b1, 16'h0103, 1'b0);
        check8("rw_same_old", fx_q, 8'h02);
        idle(1);
        bus_rd(16'h0103, "rw_same_new", 8'h09);

        // rx_syn edge counting.
        for (int p = 0; p < 5; p++) begin
            rx_syn = 1'b1;
            idle(3);
            rx_syn = 1'b0;
            idle(3);
        end
        bus_rd(16'h0107, "rxcnt5", RXEN ? 8'h05 : 8'h00);
        rx_syn = 1'b1;
        idle(3);
        bus_rd(16'h0104, "status_rx", RXEN ? 8'h04 : 8'h00);
        rx_syn = 1'b0;
        idle(3);
        bus_wr(16'h0100, 8'h04);
        bus_rd(16'h0107, "rxcnt_clr", 8'h00);
        bus_rd(16'h0105, "cnt_clr", 8'h00);

        // Reset asserted mid-pulse.
        bus_wr(16'h0101, 8'h08);
        bus_wr(16'h0103, 8'h04);
        bus_wr(16'h0100, 8'h01);
        tick_chk("pre_rst_k1", 1'b1);
        rst_n = 1'b0;
        idle(1);
        check8("rst_mid_tx", {7'd0, tx_syn}, 8'h00);
        rst_n = 1'b1;
        idle(1);
        bus_rd(16'h0100, "rst2_ctrl", 8'h00);
        bus_rd(16'h0103, "rst2_width", 8'h01);
        bus_rd(16'h0101, "rst2_perl", 8'h00);
        bus_rd(16'h0104, "rst2_status", 8'h00);
        tick_chk("rst2_tick", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
